alu_32_bit: RTL and testbench
=============================

ALU_32_BIT -- requirements
Module: alu_32_bit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 Clk  input  1  clock; HI/LO register updates occur on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 ALUControl  input  5  operation select; encoding per REQ-010.
REQ-005 A  input  32  operand A (rs data).
REQ-006 B  input  32  operand B (rt data or sign-extended immediate).
REQ-007 HiLoWrite  input  1  enables the HI/LO register write for HI/LO-writing operations.
REQ-008 Shamt  input  5  shift amount for immediate-shift operations.
REQ-009 ALUResult  output  32; Zero  output  1; Debug_HI  output  32; Debug_LO  output  32.

Function
REQ-010 Op encoding SHALL be as follows.
- 00000 ADD; 00001 SUB; 00010 AND; 00011 OR; 00100 XOR; 00101 NOR.
- 00110 SLT (signed); 00111 SLTU.
- 01000 SLL B<<Shamt; 01001 SRL; 01010 SRA.
- 01011 SLLV B<<A[4:0]; 01100 SRLV; 01101 SRAV.
- 01110 LUI B<<16; 01111 MUL low 32 bits of signed A*B.
- 10000 MULT; 10001 MULTU; 10010 MADD; 10011 MSUB.
- 10100 MTHI; 10101 MTLO; 10110 MFHI; 10111 MFLO.
- 11000 ROTR by Shamt; 11001 ROTRV by A[4:0]; 11010 SEB sign-extend B[7:0]; 11011 SEH sign-extend B[15:0].
REQ-011 ALUResult SHALL be purely combinational from ALUControl, A, B, Shamt and the current HI/LO, with zero cycles of latency.
REQ-012 ADD, SUB and MUL SHALL wrap modulo 2^32; overflow SHALL NOT be flagged or trapped.
REQ-013 SLT and SLTU SHALL produce 32'd1 when A<B and 32'd0 otherwise.
REQ-014 Shifts and rotates SHALL use only the 5-bit amount; an amount of 0 SHALL return B unchanged.
REQ-015 Zero SHALL be 1 exactly when ALUResult equals 32'd0, for every op.
REQ-016 Unused encodings (11100-11111) SHALL drive ALUResult=0 and SHALL NOT modify HI/LO.
REQ-017 MULT, MULTU, MADD, MSUB, MTHI and MTLO SHALL drive ALUResult=0.
REQ-018 HI/LO updates SHALL occur on the rising edge of Clk only when HiLoWrite=1 and the op is HI/LO-writing. The updates are:
- MULT: {HI,LO} <= signed A*B.
- MULTU: {HI,LO} <= unsigned A*B.
- MADD: {HI,LO} <= {HI,LO} + signed A*B.
- MSUB: {HI,LO} <= {HI,LO} - signed A*B.
- MTHI: HI <= A, LO unchanged.
- MTLO: LO <= A, HI unchanged.
REQ-019 When HiLoWrite=0, or the op is not HI/LO-writing, HI/LO SHALL hold their values.
REQ-020 MFHI/MFLO SHALL output the pre-edge register value; a same-cycle write becomes visible the next cycle.
REQ-021 MADD/MSUB 64-bit accumulation SHALL wrap modulo 2^64.
REQ-022 Debug_HI and Debug_LO SHALL continuously reflect the HI and LO registers.

Reset
REQ-023 Reset=0 SHALL asynchronously clear HI and LO to 0, so Debug_HI=Debug_LO=0 immediately.
REQ-024 Reset SHALL override HiLoWrite at any time, including mid-cycle.
REQ-025 Combinational ALUResult and Zero SHALL remain functional during reset, with MFHI/MFLO returning 0.

Configuration
REQ-026 With macro ALU_MADD_MSUB_EN defined, MADD and MSUB SHALL behave per REQ-018.
REQ-027 Without ALU_MADD_MSUB_EN, MADD and MSUB SHALL behave as unused encodings: ALUResult=0 and HI/LO unchanged.

Verification
REQ-028 ADD A=7, B=FFFFFFF9 -> ALUResult=0, Zero=1; SUB A=5, B=6 -> FFFFFFFF, Zero=0.
REQ-029 SLT A=FFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0; SRA B=80000000, Shamt=4 -> F8000000; ROTR B=00000001, Shamt=1 -> 80000000.
REQ-030 MULT A=FFFFFFFE, B=3, HiLoWrite=1, one clock -> HI=FFFFFFFF, LO=FFFFFFFA; MFLO in the next cycle -> FFFFFFFA.
REQ-031 Sequence with ALU_MADD_MSUB_EN defined -> HI=0, LO=0x16:
- MTLO A=10, HiLoWrite=1, one edge.
- MADD A=3, B=4, HiLoWrite=1, one edge.
REQ-032 MULTU A=FFFFFFFF, B=2 with HiLoWrite=0 -> HI/LO unchanged.
REQ-033 Assert Reset=0 between clock edges -> Debug_HI and Debug_LO become 0 without a clock edge.

Source files
------------

// File: rtl/alu_32_bit.sv
// alu_32_bit: single-cycle MIPS-style ALU with HI/LO multiply/move registers.
// Define ALU_MADD_MSUB_EN to enable MADD/MSUB accumulation into HI/LO.
module alu_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiLoWrite,
    input  logic [4:0]       Shamt,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] Debug_HI,
    output logic [WIDTH-1:0] Debug_LO
);
    logic [2*WIDTH-1:0] hiLo, accNext, prodS, prodU;
    logic [4:0]         varAmt;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [4:0] n);
        // a zero amount shifts the left half out entirely, leaving v
        return (v >> n) | (v << (6'd32 - {1'b0, n}));
    endfunction

    assign varAmt = A[4:0];
    assign prodS  = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    assign prodU  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            5'b00000: ALUResult = A + B;
            5'b00001: ALUResult = A - B;
            5'b00010: ALUResult = A & B;
            5'b00011: ALUResult = A | B;
            5'b00100: ALUResult = A ^ B;
            5'b00101: ALUResult = ~(A | B);
            5'b00110: ALUResult = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            5'b00111: ALUResult = {{(WIDTH-1){1'b0}}, A < B};
            5'b01000: ALUResult = B << Shamt;
            5'b01001: ALUResult = B >> Shamt;
            5'b01010: ALUResult = $signed(B) >>> Shamt;
            5'b01011: ALUResult = B << varAmt;
            5'b01100: ALUResult = B >> varAmt;
            5'b01101: ALUResult = $signed(B) >>> varAmt;
            5'b01110: ALUResult = B << 16;
            5'b01111: ALUResult = prodS[WIDTH-1:0];
            5'b10110: ALUResult = hiLo[2*WIDTH-1:WIDTH];
            5'b10111: ALUResult = hiLo[WIDTH-1:0];
            5'b11000: ALUResult = rotr(B, Shamt);
            5'b11001: ALUResult = rotr(B, varAmt);
            5'b11010: ALUResult = {{(WIDTH-8){B[7]}}, B[7:0]};
            5'b11011: ALUResult = {{(WIDTH-16){B[15]}}, B[15:0]};
            default:  ALUResult = '0;
        endcase
    end

    assign Zero = ALUResult == '0;

    always_comb begin
        accNext = hiLo;
        case (ALUControl)
            5'b10000: accNext = prodS;
            5'b10001: accNext = prodU;
`ifdef ALU_MADD_MSUB_EN
            5'b10010: accNext = hiLo + prodS;
            5'b10011: accNext = hiLo - prodS;
`endif
            5'b10100: accNext = {A, hiLo[WIDTH-1:0]};
            5'b10101: accNext = {hiLo[2*WIDTH-1:WIDTH], A};
            default:  accNext = hiLo;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            hiLo <= '0;
        else if (HiLoWrite)
            hiLo <= accNext;
    end

    assign Debug_HI = hiLo[2*WIDTH-1:WIDTH];
    assign Debug_LO = hiLo[WIDTH-1:0];
endmodule

// File: tb/tb_alu_32_bit.sv
// tb_alu_32_bit: directed-vector self-checking bench for alu_32_bit.
// MADD/MSUB expectations follow whether ALU_MADD_MSUB_EN is defined.
module tb_alu_32_bit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [4:0]  ALUControl = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        HiLoWrite = 1'b0;
    logic [4:0]  Shamt = '0;
    logic [31:0] ALUResult, Debug_HI, Debug_LO;
    logic        Zero;
    int          checks = 0;
    int          errors = 0;

    alu_32_bit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .ALUControl(ALUControl), .A(A), .B(B),
        .HiLoWrite(HiLoWrite), .Shamt(Shamt), .ALUResult(ALUResult), .Zero(Zero),
        .Debug_HI(Debug_HI), .Debug_LO(Debug_LO)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic we);
        ALUControl = op;
        A = a;
        B = b;
        Shamt = sh;
        HiLoWrite = we;
        #1;
    endtask

    task automatic expectRes(input string tag, input logic [31:0] exp);
        checkVal(tag, ALUResult, exp);
        checkVal({tag, "_zero"}, {31'b0, Zero}, {31'b0, exp == 32'h0});
    endtask

    task automatic expectHiLo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        checkVal({tag, "_hi"}, Debug_HI, hi);
        checkVal({tag, "_lo"}, Debug_LO, lo);
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1;
        expectHiLo("reset", 32'h0, 32'h0);
        apply(5'b00000, 32'd1, 32'd2, 5'd0, 1'b1);
        expectRes("add_in_reset", 32'd3);
        apply(5'b10110, 32'd0, 32'd0, 5'd0, 1'b0);
        expectRes("mfhi_in_reset", 32'd0);
        tick;
        Reset = 1'b1;

        apply(5'b00000, 32'd7, 32'hFFFFFFF9, 5'd0, 1'b0); expectRes("add_wrap", 32'h0);
        apply(5'b00001, 32'd5, 32'd6, 5'd0, 1'b0);        expectRes("sub", 32'hFFFFFFFF);
        apply(5'b00010, 32'h12345678, 32'h0F0F0F0F, 5'd0, 1'b0); expectRes("and", 32'h02040608);
        apply(5'b00011, 32'h12345678, 32'h0F0F0F0F, 5'd0, 1'b0); expectRes("or", 32'h1F3F5F7F);
        apply(5'b00100, 32'h12345678, 32'h0F0F0F0F, 5'd0, 1'b0); expectRes("xor", 32'h1D3B5977);
        apply(5'b00101, 32'h0, 32'h0, 5'd0, 1'b0);        expectRes("nor", 32'hFFFFFFFF);
        apply(5'b00110, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0); expectRes("slt", 32'd1);
        apply(5'b00111, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0); expectRes("sltu", 32'd0);
        apply(5'b01000, 32'h0, 32'h1, 5'd31, 1'b0);       expectRes("sll", 32'h80000000);
        apply(5'b01001, 32'h0, 32'h80000000, 5'd4, 1'b0); expectRes("srl", 32'h08000000);
        apply(5'b01001, 32'h0, 32'hDEADBEEF, 5'd0, 1'b0); expectRes("srl_zero", 32'hDEADBEEF);
        apply(5'b01010, 32'h0, 32'h80000000, 5'd4, 1'b0); expectRes("sra", 32'hF8000000);
        apply(5'b01011, 32'h24, 32'h3, 5'd0, 1'b0);       expectRes("sllv", 32'h30);
        apply(5'b01100, 32'h3, 32'hF0, 5'd0, 1'b0);       expectRes("srlv", 32'h1E);
        apply(5'b01101, 32'h1F, 32'h80000000, 5'd0, 1'b0); expectRes("srav", 32'hFFFFFFFF);
        apply(5'b01110, 32'h0, 32'h1234, 5'd0, 1'b0);     expectRes("lui", 32'h12340000);
        apply(5'b01111, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0); expectRes("mul", 32'hFFFFFFFA);
        apply(5'b11000, 32'h0, 32'h1, 5'd1, 1'b0);        expectRes("rotr", 32'h80000000);
        apply(5'b11000, 32'h0, 32'hDEADBEEF, 5'd0, 1'b0); expectRes("rotr_zero", 32'hDEADBEEF);
        apply(5'b11001, 32'h4, 32'h12345678, 5'd0, 1'b0); expectRes("rotrv", 32'h81234567);
        apply(5'b11010, 32'h0, 32'h00000080, 5'd0, 1'b0); expectRes("seb", 32'hFFFFFF80);
        apply(5'b11011, 32'h0, 32'h00018000, 5'd0, 1'b0); expectRes("seh", 32'hFFFF8000);
        apply(5'b11011, 32'h0, 32'h00007FFF, 5'd0, 1'b0); expectRes("seh_pos", 32'h00007FFF);
        apply(5'b11100, 32'd5, 32'd6, 5'd3, 1'b0);        expectRes("unused", 32'h0);

        apply(5'b10000, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b1);
        expectRes("mult_res", 32'h0);
        tick;
        expectHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        apply(5'b10111, 32'h0, 32'h0, 5'd0, 1'b0); expectRes("mflo", 32'hFFFFFFFA);
        apply(5'b10110, 32'h0, 32'h0, 5'd0, 1'b0); expectRes("mfhi", 32'hFFFFFFFF);
        apply(5'b10001, 32'hFFFFFFFF, 32'd2, 5'd0, 1'b0);
        tick;
        expectHiLo("multu_nowrite", 32'hFFFFFFFF, 32'hFFFFFFFA);
        apply(5'b10001, 32'hFFFFFFFF, 32'd2, 5'd0, 1'b1);
        tick;
        expectHiLo("multu", 32'h1, 32'hFFFFFFFE);
        apply(5'b10100, 32'hAAAA5555, 32'h0, 5'd0, 1'b1);
        expectRes("mthi_res", 32'h0);
        checkVal("mthi_pre_edge", Debug_HI, 32'h1);
        tick;
        expectHiLo("mthi", 32'hAAAA5555, 32'hFFFFFFFE);
        apply(5'b10100, 32'h0, 32'h0, 5'd0, 1'b1);
        tick;
        apply(5'b10101, 32'd10, 32'h0, 5'd0, 1'b1);
        tick;
        expectHiLo("mtlo", 32'h0, 32'd10);

        apply(5'b10010, 32'd3, 32'd4, 5'd0, 1'b1);
        expectRes("madd_res", 32'h0);
        tick;
`ifdef ALU_MADD_MSUB_EN
        expectHiLo("madd", 32'h0, 32'h16);
        apply(5'b10011, 32'd1, 32'd32, 5'd0, 1'b1);
        tick;
        expectHiLo("msub_wrap", 32'hFFFFFFFF, 32'hFFFFFFF6);
`else
        expectHiLo("madd_off", 32'h0, 32'd10);
        apply(5'b10011, 32'd1, 32'd32, 5'd0, 1'b1);
        expectRes("msub_res", 32'h0);
        tick;
        expectHiLo("msub_off", 32'h0, 32'd10);
`endif
        apply(5'b10100, 32'h13572468, 32'h0, 5'd0, 1'b1);
        tick;
        apply(5'b11111, 32'h123, 32'h456, 5'd0, 1'b1);
        tick;
        checkVal("unused_hold_hi", Debug_HI, 32'h13572468);

        #2;
        Reset = 1'b0;
        #1;
        expectHiLo("async_reset", 32'h0, 32'h0);
        apply(5'b10101, 32'h55, 32'h0, 5'd0, 1'b1);
        tick;
        expectHiLo("reset_override", 32'h0, 32'h0);
        apply(5'b10111, 32'h0, 32'h0, 5'd0, 1'b0);
        expectRes("mflo_in_reset", 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
